// File: rtl/fifo.sv
// ----------------------------------------------------------------------------
// fifo
//   Single-clock FIFO with a show-ahead (first-word-fall-through) read port.
//   Capacity may be any integer >= 1; pointers wrap by explicit compare, so
//   non-power-of-two depths use exactly p_CAPACITY storage words.
//
// Ports
//   clk     in   1        rising-edge clock for all state
//   rst     in   1        synchronous active-high reset (pointers/count/flags)
//   wrdata  in   p_WIDTH  word to push
//   wrena   in   1        push request; accepted when not full
//   rdena   in   1        pop request; accepted when not empty
//   rddata  out  p_WIDTH  head word, combinational from storage; valid when !empty
//   full    out  1        registered, count == p_CAPACITY
//   empty   out  1        registered, count == 0
//   count   out  CNT_W    number of stored words
// ----------------------------------------------------------------------------
module fifo #(
    parameter int p_WIDTH    = 8,
    parameter int p_CAPACITY = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [p_WIDTH-1:0]                wrdata,
    input  logic                              wrena,
    input  logic                              rdena,
    output logic [p_WIDTH-1:0]                rddata,
    output logic                              full,
    output logic                              empty,
    output logic [$clog2(p_CAPACITY+1)-1:0]   count
);

    localparam int CNT_W = $clog2(p_CAPACITY + 1);
    // A single-entry FIFO still needs a 1-bit pointer to form a legal vector.
    localparam int PTR_W = (p_CAPACITY > 1) ? $clog2(p_CAPACITY) : 1;

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(p_CAPACITY - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(p_CAPACITY);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [p_WIDTH-1:0] mem_q [p_CAPACITY];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             full_q,   full_d;
    logic             empty_q,  empty_d;

    logic push_acc;
    logic pop_acc;

    // Flags are registered, so acceptance depends only on state: no
    // combinational path from rdena to the write side or vice versa. This is
    // also why a push into an empty FIFO cannot be popped in the same cycle.
    assign push_acc = wrena && !full_q;
    assign pop_acc  = rdena && !empty_q;

    // NOTE: every variable driven here gets a default first so no latch is
    // inferred on paths that do not assign it.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push_acc) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop_acc) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end

        unique case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        full_d  = (count_d == CNT_MAX);
        empty_d = (count_d == '0);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; the cleared pointers
    // and empty flag make its old contents unreachable, and leaving it out of
    // reset lets it map onto plain flops or distributed RAM.
    always_ff @(posedge clk) begin
        if (!rst && push_acc) begin
            mem_q[wr_ptr_q] <= wrdata;
        end
    end

    assign rddata = mem_q[rd_ptr_q];
    assign full   = full_q;
    assign empty  = empty_q;
    assign count  = count_q;

endmodule

// File: tb/tb_fifo.sv
// ----------------------------------------------------------------------------
// tb_fifo
//   Directed self-checking bench for fifo with p_WIDTH=3, p_CAPACITY=7.
//   Inputs change 1 time unit after a rising edge; outputs are sampled there
//   too, so every check sees settled post-edge (or pre-next-edge) values.
// ----------------------------------------------------------------------------
module tb_fifo;

    localparam int W   = 3;
    localparam int CAP = 7;

    logic         clk;
    logic         rst;
    logic [W-1:0] wrdata;
    logic         wrena;
    logic         rdena;
    logic [W-1:0] rddata;
    logic         full;
    logic         empty;
    logic [2:0]   count;

    int tests_run;
    int tests_failed;

    fifo #(.p_WIDTH(W), .p_CAPACITY(CAP)) dut (
        .clk    (clk),
        .rst    (rst),
        .wrdata (wrdata),
        .wrena  (wrena),
        .rdena  (rdena),
        .rddata (rddata),
        .full   (full),
        .empty  (empty),
        .count  (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic check_flags(input string tag, input logic [2:0] exp_count,
                               input logic exp_full, input logic exp_empty);
        check({tag, ".count"}, 32'(count), 32'(exp_count));
        check({tag, ".full"},  32'(full),  32'(exp_full));
        check({tag, ".empty"}, 32'(empty), 32'(exp_empty));
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst    = 1'b1;
        wrena  = 1'b0;
        rdena  = 1'b0;
        wrdata = '0;

        // 1. Reset held for 5 cycles, then released.
        repeat (5) tick();
        check_flags("reset_held", 3'd0, 1'b0, 1'b1);
        rst = 1'b0;
        tick();
        check_flags("reset_release", 3'd0, 1'b0, 1'b1);

        // 2. Fill with 0..6; full only after the 7th edge; 8th push dropped.
        for (int i = 0; i < CAP; i++) begin
            wrena  = 1'b1;
            wrdata = W'(i);
            tick();
            check_flags($sformatf("fill%0d", i), 3'(i + 1), (i == CAP - 1), 1'b0);
            check("fill_head", 32'(rddata), 32'd0);
        end
        wrdata = 3'd7;
        tick();
        wrena = 1'b0;
        check_flags("push_when_full", 3'd7, 1'b1, 1'b0);
        check("push_when_full.head", 32'(rddata), 32'd0);

        // 3. Drain: popped word is on rddata during its pop cycle.
        for (int i = 0; i < CAP; i++) begin
            rdena = 1'b1;
            check($sformatf("drain%0d.data", i), 32'(rddata), 32'(i));
            tick();
            check_flags($sformatf("drain%0d", i), 3'(CAP - 1 - i), 1'b0, (i == CAP - 1));
        end
        tick();
        rdena = 1'b0;
        check_flags("pop_when_empty", 3'd0, 1'b0, 1'b1);

        // 4. Reset after n pushes discards contents; pointers restart at 0.
        for (int n = 1; n <= CAP; n++) begin
            wrena = 1'b1;
            for (int j = 0; j < n; j++) begin
                wrdata = W'(n + j + 1);
                tick();
            end
            wrena = 1'b0;
            check($sformatf("pre_reset%0d.count", n), 32'(count), 32'(n));
            rst = 1'b1;
            tick();
            rst = 1'b0;
            check_flags($sformatf("mid_reset%0d", n), 3'd0, 1'b0, 1'b1);
            wrena  = 1'b1;
            wrdata = 3'd0;
            tick();
            wrena = 1'b0;
            check($sformatf("post_reset%0d.data", n), 32'(rddata), 32'd0);
            check($sformatf("post_reset%0d.count", n), 32'(count), 32'd1);
            rdena = 1'b1;
            tick();
            rdena = 1'b0;
            check($sformatf("post_reset%0d.empty", n), 32'(empty), 32'd1);
        end

        // Reset wins over a concurrent push.
        rst    = 1'b1;
        wrena  = 1'b1;
        wrdata = 3'd5;
        tick();
        rst   = 1'b0;
        wrena = 1'b0;
        check_flags("reset_vs_push", 3'd0, 1'b0, 1'b1);

        // 5. Push k, pop one cycle later, 70 times.
        for (int k = 0; k < 70; k++) begin
            wrena  = 1'b1;
            wrdata = W'(k);
            tick();
            wrena = 1'b0;
            rdena = 1'b1;
            check($sformatf("interleave%0d.data", k), 32'(rddata), 32'(k % 8));
            check("interleave.full", 32'(full), 32'd0);
            tick();
            rdena = 1'b0;
        end
        check("interleave_end.empty", 32'(empty), 32'd1);

        // Simultaneous push/pop on empty: only the push is accepted.
        wrena  = 1'b1;
        rdena  = 1'b1;
        wrdata = 3'd1;
        tick();
        rdena  = 1'b0;
        check_flags("both_when_empty", 3'd1, 1'b0, 1'b0);
        check("both_when_empty.data", 32'(rddata), 32'd1);

        // 6. Reach count=3 (words 1,2,3), then 10 cycles of push+pop.
        //    Pointers start at 70%7=0, so the write pointer wraps 6->0.
        for (int i = 2; i <= 3; i++) begin
            wrdata = W'(i);
            tick();
        end
        check("steady_start.count", 32'(count), 32'd3);
        rdena = 1'b1;
        for (int c = 0; c < 10; c++) begin
            wrdata = W'(4 + c);
            check($sformatf("steady%0d.data", c), 32'(rddata), 32'((1 + c) % 8));
            tick();
            check($sformatf("steady%0d.count", c), 32'(count), 32'd3);
        end
        wrena = 1'b0;
        // Remaining words are 11,12,13 truncated to 3 bits: 3,4,5.
        for (int i = 0; i < 3; i++) begin
            check($sformatf("steady_drain%0d", i), 32'(rddata), 32'(3 + i));
            tick();
        end
        rdena = 1'b0;
        check_flags("steady_end", 3'd0, 1'b0, 1'b1);

        // Simultaneous push/pop on full: only the pop is accepted.
        wrena = 1'b1;
        for (int i = 0; i < CAP; i++) begin
            wrdata = W'(i + 2);
            tick();
        end
        check("refill.full", 32'(full), 32'd1);
        rdena  = 1'b1;
        wrdata = 3'd0;
        check("both_when_full.head", 32'(rddata), 32'd2);
        tick();
        wrena = 1'b0;
        rdena = 1'b0;
        check_flags("both_when_full", 3'd6, 1'b0, 1'b0);
        check("both_when_full.next", 32'(rddata), 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
